apu_audio_decimator: RTL and testbench

//  Upstream stage of the codec DAC serializer: converts the APU mixer's unsigned 16-bit

---
 rtl/apu_audio_decimator.sv | 120 ++++++++++++
 tb/tb_apu_audio_decimator.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/apu_audio_decimator.sv
// apu_audio_decimator
//   Converts the APU mixer's unsigned 16-bit samples into signed 16-bit PCM at
//   the DAC frame rate. A 2^LOG2_TAPS-tap boxcar (running sum over a circular
//   buffer) low-passes the input. Its mean is registered once per DAC frame, on
//   the rising edge of dac_lrck, so the serializer never sees a word change
//   mid-shift.
//
//   Optional feature: define AUDIO_DC_BLOCK_EN to add a one-pole DC-blocking
//   high-pass (pole set by DC_SHIFT) after the boxcar.
//
// Ports
//   clk          system clock (dac_lrck is generated in this domain)
//   rst          synchronous reset, active-high
//   apu_sample   unsigned mixer sample, 16'h8000 = silence
//   apu_valid    1-cycle strobe qualifying apu_sample
//   mute         forces a zero output word at the next frame update
//   dac_lrck     LR clock from the DAC serializer
//   audio        signed PCM word, stable between frame updates
//   sample_tick  1-cycle pulse in the cycle audio takes a new value
module apu_audio_decimator #(
  parameter int LOG2_TAPS = 5,
  parameter int DC_SHIFT  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] apu_sample,
  input  logic        apu_valid,
  input  logic        mute,
  input  logic        dac_lrck,
  output logic [15:0] audio,
  output logic        sample_tick
);

  localparam int TAPS = 1 << LOG2_TAPS;
  localparam int SW   = 16 + LOG2_TAPS;

  if (LOG2_TAPS < 2 || LOG2_TAPS > 6 || DC_SHIFT < 1 || DC_SHIFT > 17) begin : g_param_chk
    $error("apu_audio_decimator: parameter out of range");
  end

  logic [15:0]          sbuf [TAPS];
  logic [LOG2_TAPS-1:0] wr_ptr;
  logic [SW-1:0]        sum;
  logic                 lrck_q;
  logic                 frame_edge;
  logic [15:0]          mean;
  logic signed [15:0]   x;

  assign frame_edge = dac_lrck & ~lrck_q;
  assign mean       = sum[SW-1:LOG2_TAPS];
  // Subtracting midscale from a 16-bit unsigned value is just an MSB flip.
  assign x          = signed'(mean ^ 16'h8000);

  // Boxcar: replace the oldest sample in the window with the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) sbuf[i] <= 16'h8000;
      sum    <= SW'(TAPS) << 15;
      wr_ptr <= '0;
    end else if (apu_valid) begin
      sum          <= sum - SW'(sbuf[wr_ptr]) + SW'(apu_sample);
      sbuf[wr_ptr] <= apu_sample;
      wr_ptr       <= wr_ptr + 1'b1;
    end
  end

`ifdef AUDIO_DC_BLOCK_EN
  logic signed [15:0] x_prev;
  logic signed [17:0] y_prev;
  logic signed [19:0] y_full;
  logic signed [17:0] y;
  logic signed [15:0] y_sat;

  always_comb begin
    y_full = 20'(x) - 20'(x_prev) + 20'(y_prev) - 20'(y_prev >>> DC_SHIFT);
    y      = y_full[17:0];
    if (y > 18'sd32767)       y_sat = 16'sh7FFF;
    else if (y < -18'sd32768) y_sat = 16'sh8000;
    else                      y_sat = y[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lrck_q      <= 1'b0;
      audio       <= '0;
      sample_tick <= 1'b0;
      x_prev      <= '0;
      y_prev      <= '0;
    end else begin
      lrck_q      <= dac_lrck;
      sample_tick <= frame_edge;
      if (frame_edge) begin
        x_prev <= x;
        if (mute) begin
          audio  <= '0;
          y_prev <= '0;
        end else begin
          audio  <= y_sat;
          y_prev <= y;
        end
      end
    end
  end
`else
  // Frame update: the sum sampled here is the pre-update value, so a strobe
  // coincident with the edge lands in the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      lrck_q      <= 1'b0;
      audio       <= '0;
      sample_tick <= 1'b0;
    end else begin
      lrck_q      <= dac_lrck;
      sample_tick <= frame_edge;
      if (frame_edge) audio <= mute ? 16'h0000 : x;
    end
  end
`endif

endmodule

// File: tb/tb_apu_audio_decimator.sv
module tb_apu_audio_decimator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] apu_sample = '0;
  logic        apu_valid = 1'b0;
  logic        mute = 1'b0;
  logic        dac_lrck = 1'b0;
  logic [15:0] audio;
  logic        sample_tick;

  int tests = 0;
  int fails = 0;

  // reference model: sliding window of the last 32 samples
  logic [15:0] win[$];
  int xp, yp;

  always #5 clk = ~clk;

  apu_audio_decimator #(.LOG2_TAPS(5), .DC_SHIFT(8)) dut (
    .clk(clk), .rst(rst), .apu_sample(apu_sample), .apu_valid(apu_valid),
    .mute(mute), .dac_lrck(dac_lrck), .audio(audio), .sample_tick(sample_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    win = {};
    for (int i = 0; i < 32; i++) win.push_back(16'h8000);
    xp = 0;
    yp = 0;
  endtask

  task automatic model_push(input logic [15:0] s);
    void'(win.pop_front());
    win.push_back(s);
  endtask

  function automatic logic [15:0] model_out(input logic m);
    int s, xv, y;
    s = 0;
    foreach (win[i]) s += int'(win[i]);
    xv = (s / 32) - 32768;            // signed offset from midscale
`ifdef AUDIO_DC_BLOCK_EN
    if (m) begin
      xp = xv; yp = 0;
      return 16'h0000;
    end
    y = xv - xp + yp - (yp >>> 8);
    y = (y <<< 14) >>> 14;            // keep 18-bit signed state
    xp = xv; yp = y;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return 16'(y);
`else
    y = xv;
    return m ? 16'h0000 : 16'(y);
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1; apu_valid = 1'b0; dac_lrck = 1'b0; mute = 1'b0;
    step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic push(input logic [15:0] s);
    apu_sample = s; apu_valid = 1'b1;
    step();
    apu_valid = 1'b0;
    model_push(s);
  endtask

  task automatic do_edge(input string tag, input logic m, input logic col, input logic [15:0] cs);
    logic [15:0] e;
    e = model_out(m);
    dac_lrck = 1'b1; mute = m; apu_valid = col; apu_sample = cs;
    step();
    if (col) model_push(cs);
    apu_valid = 1'b0; mute = 1'b0;
    chk({tag, ".audio"}, 32'(audio), 32'(e));
    chk({tag, ".tick"}, 32'(sample_tick), 32'd1);
    step();
    chk({tag, ".hold"}, 32'(audio), 32'(e));
    chk({tag, ".tick_off"}, 32'(sample_tick), 32'd0);
    dac_lrck = 1'b0;
    step();
  endtask

  initial begin
    logic [15:0] held;
    logic        bad;
    step();
    do_reset();

    // reset state
    chk("rst.audio", 32'(audio), 32'd0);
    chk("rst.tick", 32'(sample_tick), 32'd0);
    chk("rst.sum", 32'(dut.sum), 32'h0010_0000);
    chk("rst.ptr", 32'(dut.wr_ptr), 32'd0);
    do_edge("idle_edge", 1'b0, 1'b0, 16'h0);

    // half fill then full fill
    for (int i = 0; i < 16; i++) push(16'hC000);
    do_edge("half_fill", 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 16; i++) push(16'hC000);
    do_edge("full_fill", 1'b0, 1'b0, 16'h0);

    // collision: edge sees the pre-update sum
    do_edge("collide", 1'b0, 1'b1, 16'h4000);
    do_edge("after_collide", 1'b0, 1'b0, 16'h0);

    // mute then unmute; boxcar keeps running while muted
    push(16'hF000);
    do_edge("mute", 1'b1, 1'b0, 16'h0);
    push(16'h1234);
    do_edge("unmute", 1'b0, 1'b0, 16'h0);

    // no frame edges for 1000 cycles: output holds, no tick
    held = audio;
    bad  = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (i % 7 == 0) begin
        apu_sample = 16'($urandom); apu_valid = 1'b1;
        model_push(apu_sample);
      end
      step();
      apu_valid = 1'b0;
      if (audio !== held || sample_tick !== 1'b0) bad = 1'b1;
    end
    chk("no_edge_hold", 32'(bad), 32'd0);
    do_edge("post_idle", 1'b0, 1'b0, 16'h0);

    // constant input across several frames
    do_reset();
    for (int i = 0; i < 32; i++) push(16'hC000);
    for (int k = 0; k < 3; k++) do_edge("const", 1'b0, 1'b0, 16'h0);

    // mid-operation reset discards history
    for (int i = 0; i < 5; i++) push(16'($urandom));
    do_reset();
    chk("midrst.ptr", 32'(dut.wr_ptr), 32'd0);
    chk("midrst.sum", 32'(dut.sum), 32'h0010_0000);
    do_edge("midrst_edge", 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) push(16'h9000);
    chk("midrst.ptr3", 32'(dut.wr_ptr), 32'd3);

    // randomized frames
    for (int n = 0; n < 40; n++) begin
      int cnt;
      cnt = $urandom_range(0, 45);
      for (int i = 0; i < cnt; i++) begin
        push(16'($urandom));
        if ($urandom_range(0, 3) == 0) step();
      end
      do_edge("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
